// File: rtl/vc_rr_mux.sv
// N-virtual-channel multiplexer: one small FIFO per VC, drained round-robin onto
// a single registered output bus with a one-hot source-VC valid.
module vc_rr_mux #(
  parameter int BITNUMBER  = 5,
  parameter int NUM_VC     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_VC-1:0]           valid_vc,
  input  logic [NUM_VC*BITNUMBER-1:0] data_in,
  input  logic                        pause,
  output logic [BITNUMBER-1:0]        data_out,
  output logic [NUM_VC-1:0]           valid_out,
  output logic [NUM_VC-1:0]           fifo_full,
  output logic [NUM_VC-1:0]           fifo_empty,
  output logic [NUM_VC-1:0]           overflow
);

  // Flow control: valid_vc[i] offers one word per cycle with no back-pressure;
  // a word offered to a full FIFO that is not popped that same cycle is dropped
  // and overflow[i] latches. pause=1 suppresses the pop for that cycle only;
  // valid_out is a one-cycle pulse per delivered word.

  localparam int              IDX_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_C = IDX_W'(NUM_VC - 1);

  logic [BITNUMBER-1:0] mem    [NUM_VC][FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr [NUM_VC];
  logic [PTR_W-1:0]     rd_ptr [NUM_VC];
  logic [PTR_W:0]       count  [NUM_VC];

  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_any;
  logic [NUM_VC-1:0]    nonempty;
  logic [NUM_VC-1:0]    pop;
  logic [NUM_VC-1:0]    push;
  logic [NUM_VC-1:0]    drop;

  // Status flags come straight from the registered counts, no lookahead.
  always_comb begin
    nonempty   = '0;
    fifo_full  = '0;
    fifo_empty = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      nonempty[i]   = (count[i] != '0);
      fifo_full[i]  = (count[i] == DEPTH_C);
      fifo_empty[i] = (count[i] == '0);
    end
  end

  // Round-robin search starting just after the last granted VC.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    grant_any = 1'b0;
    grant_idx = last_grant;
    for (int k = 1; k <= NUM_VC; k++) begin
      cand     = (int'(last_grant) + k) % NUM_VC;
      cand_idx = IDX_W'(cand);
      if (!grant_any && nonempty[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
    if (pause) begin
      grant_any = 1'b0;
    end
  end

  always_comb begin
    pop = '0;
    if (grant_any) begin
      pop[grant_idx] = 1'b1;
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  always_comb begin
    push = '0;
    drop = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      push[i] = valid_vc[i] && ((count[i] != DEPTH_C) || pop[i]);
      drop[i] = valid_vc[i] && (count[i] == DEPTH_C) && !pop[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VC; i++) begin
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
        count[i]    <= '0;
        overflow[i] <= 1'b0;
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          mem[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= data_in[i*BITNUMBER +: BITNUMBER];
          wr_ptr[i]         <= wr_ptr[i] + 1'b1;
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
        if (drop[i]) begin
          overflow[i] <= 1'b1;
        end
      end
    end
  end

  // Output register; data_out keeps its last word when nothing is granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      valid_out  <= '0;
      last_grant <= LAST_C;
    end else begin
      valid_out <= pop;
      if (grant_any) begin
        data_out   <= mem[grant_idx][rd_ptr[grant_idx]];
        last_grant <= grant_idx;
      end
    end
  end

endmodule
